// File: rtl/wb_load_commit.sv
// Writeback stage: commits ALU results or aligned, extended load data as a one-cycle pulse.
// Define WB_HILO_COMMIT_EN to enable the HI/LO commit path.
module wb_load_commit #(
  parameter int DW = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int TIMEOUT = 15,
  localparam int OFFW = $clog2(DW / 8)
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [4:0]        wb_wa_i,
  input  logic              wb_wreg_i,
  input  logic              wb_whilo_i,
  input  logic              wb_mreg_i,
  input  logic [DW-1:0]     wb_dreg_i,
  input  logic [2*DW-1:0]   wb_dhilo_i,
  input  logic [1:0]        wb_ls_size_i,
  input  logic              wb_ls_uns_i,
  input  logic [OFFW-1:0]   wb_ls_off_i,
  input  logic              dm_valid,
  input  logic [DW-1:0]     dm,
  output logic              wb_valid_o,
  output logic [4:0]        wb_wa_o,
  output logic              wb_wreg_o,
  output logic              wb_whilo_o,
  output logic [DW-1:0]     wb_wd_o,
  output logic [DW-1:0]     wb_dhi_o,
  output logic [DW-1:0]     wb_dlo_o,
  output logic              wb_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

  state_t          state, state_nx;
  logic [7:0]      cnt, cnt_nx;
  logic            accept, commit, tmo;
  logic [4:0]      c_wa;
  logic            c_wreg;
  logic [DW-1:0]   c_wd;

  logic [4:0]      p_wa;
  logic            p_wreg;
  logic [1:0]      p_size;
  logic            p_uns;
  logic [OFFW-1:0] p_off;

  logic [1:0]      sz_eff;
  int              nbytes, off_b, pad;
  logic [DW-1:0]   top, ld_data;

  assign mem_ready = cpu_rst_n && (state != WAIT);
  assign accept    = mem_valid && mem_ready;

  // Move the addressed bytes to the top of the word, then shift right to extend.
  always_comb begin
    sz_eff = (DW == 32 && p_size == 2'd3) ? 2'd2 : p_size;
    nbytes = 1 << sz_eff;
    off_b  = 32'(p_off) & ~(nbytes - 1);
    pad    = DW - 8 * nbytes;
    if (BIG_ENDIAN != 0) top = dm << (8 * off_b);
    else                 top = (dm >> (8 * off_b)) << pad;
    if (p_uns) ld_data = top >> pad;
    else       ld_data = $signed(top) >>> pad;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    tmo      = 1'b0;
    c_wa     = wb_wa_i;
    c_wreg   = wb_wreg_i;
    c_wd     = wb_dreg_i;
    case (state)
      IDLE, COMMIT: begin
        state_nx = IDLE;
        if (accept) begin
          state_nx = wb_mreg_i ? WAIT : COMMIT;
          cnt_nx   = '0;
          commit   = !wb_mreg_i;
        end
      end
      WAIT: begin
        c_wa   = p_wa;
        c_wreg = p_wreg;
        c_wd   = ld_data;
        if (dm_valid) begin
          state_nx = COMMIT;
          commit   = 1'b1;
        end else if (cnt == 8'(TIMEOUT)) begin
          state_nx = COMMIT;
          commit   = 1'b1;
          tmo      = 1'b1;
          c_wreg   = 1'b0;
          c_wd     = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      p_wa   <= '0;
      p_wreg <= 1'b0;
      p_size <= '0;
      p_uns  <= 1'b0;
      p_off  <= '0;
    end else if (accept && wb_mreg_i) begin
      p_wa   <= wb_wa_i;
      p_wreg <= wb_wreg_i;
      p_size <= wb_ls_size_i;
      p_uns  <= wb_ls_uns_i;
      p_off  <= wb_ls_off_i;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wb_valid_o <= 1'b0;
      wb_wreg_o  <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_wa_o    <= '0;
      wb_wd_o    <= '0;
    end else begin
      wb_valid_o <= commit;
      wb_wreg_o  <= commit & c_wreg;
      wb_err_o   <= wb_err_o | tmo;
      if (commit) begin
        wb_wa_o <= c_wa;
        wb_wd_o <= c_wd;
      end
    end
  end

`ifdef WB_HILO_COMMIT_EN
  logic            p_whilo;
  logic [2*DW-1:0] p_hilo;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      p_whilo    <= 1'b0;
      p_hilo     <= '0;
      wb_whilo_o <= 1'b0;
      wb_dhi_o   <= '0;
      wb_dlo_o   <= '0;
    end else begin
      if (accept && wb_mreg_i) begin
        p_whilo <= wb_whilo_i;
        p_hilo  <= wb_dhilo_i;
      end
      wb_whilo_o <= commit & ((state == WAIT) ? p_whilo : wb_whilo_i);
      if (commit) {wb_dhi_o, wb_dlo_o} <= (state == WAIT) ? p_hilo : wb_dhilo_i;
    end
  end
`else
  logic unused_hilo;
  assign unused_hilo = ^{wb_whilo_i, wb_dhilo_i};
  assign wb_whilo_o  = 1'b0;
  assign wb_dhi_o    = '0;
  assign wb_dlo_o    = '0;
`endif

endmodule

// File: tb/tb_wb_load_commit.sv
// Scoreboard bench: big- and little-endian instances share stimulus; a monitor checks every commit.
module tb_wb_load_commit;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_valid = 1'b0, wreg = 1'b0, whilo = 1'b0, mreg = 1'b0, uns = 1'b0, dm_valid = 1'b0;
  logic [4:0] wa = '0;
  logic [DW-1:0] dreg = '0, dm = '0;
  logic [2*DW-1:0] dhilo = '0;
  logic [1:0] size = '0, off = '0;

  logic rdy_b, v_b, wreg_b, whilo_b, err_b, rdy_l, v_l, wreg_l, whilo_l, err_l;
  logic [4:0] wa_b, wa_l;
  logic [DW-1:0] wd_b, hi_b, lo_b, wd_l, hi_l, lo_l;

  wb_load_commit #(.DW(DW), .BIG_ENDIAN(1), .TIMEOUT(TO)) u_be (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .mem_valid(mem_valid), .mem_ready(rdy_b),
    .wb_wa_i(wa), .wb_wreg_i(wreg), .wb_whilo_i(whilo), .wb_mreg_i(mreg), .wb_dreg_i(dreg),
    .wb_dhilo_i(dhilo), .wb_ls_size_i(size), .wb_ls_uns_i(uns), .wb_ls_off_i(off),
    .dm_valid(dm_valid), .dm(dm), .wb_valid_o(v_b), .wb_wa_o(wa_b), .wb_wreg_o(wreg_b),
    .wb_whilo_o(whilo_b), .wb_wd_o(wd_b), .wb_dhi_o(hi_b), .wb_dlo_o(lo_b), .wb_err_o(err_b));

  wb_load_commit #(.DW(DW), .BIG_ENDIAN(0), .TIMEOUT(TO)) u_le (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .mem_valid(mem_valid), .mem_ready(rdy_l),
    .wb_wa_i(wa), .wb_wreg_i(wreg), .wb_whilo_i(whilo), .wb_mreg_i(mreg), .wb_dreg_i(dreg),
    .wb_dhilo_i(dhilo), .wb_ls_size_i(size), .wb_ls_uns_i(uns), .wb_ls_off_i(off),
    .dm_valid(dm_valid), .dm(dm), .wb_valid_o(v_l), .wb_wa_o(wa_l), .wb_wreg_o(wreg_l),
    .wb_whilo_o(whilo_l), .wb_wd_o(wd_l), .wb_dhi_o(hi_l), .wb_dlo_o(lo_l), .wb_err_o(err_l));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   cyc;
    logic [4:0]    wa;
    logic          wreg, whilo, err;
    logic [DW-1:0] wd_b, wd_l, hi, lo;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int errors = 0, checks = 0;
  bit model_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: gather bytes lane by lane, assemble in memory order, then extend.
  function automatic logic [DW-1:0] model_load(input logic [DW-1:0] d, input int sz, input bit u,
                                               input int o, input bit be);
    int n, lane;
    logic [63:0] v;
    logic [7:0] b;
    if (sz == 3) sz = 2;
    n = 1 << sz;
    o = o - (o % n);
    v = '0;
    for (int i = 0; i < n; i++) begin
      lane = o + i;
      b = be ? d[DW-1-8*lane -: 8] : d[8*lane +: 8];
      if (be) v = (v << 8) | 64'(b);
      else    v = v | (64'(b) << (8 * i));
    end
    if (!u && v[8*n-1]) v = v | ({64{1'b1}} << (8 * n));
    return v[DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (v_b || v_l) begin
        chk("valid_pair", {62'd0, v_b, v_l}, 64'd3);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got valid with empty scoreboard (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("commit_cycle", 64'(cyc), 64'(e.cyc));
          chk("wa_b", 64'(wa_b), 64'(e.wa));
          chk("wa_l", 64'(wa_l), 64'(e.wa));
          chk("wreg", {62'd0, wreg_b, wreg_l}, {62'd0, e.wreg, e.wreg});
          chk("whilo", {62'd0, whilo_b, whilo_l}, {62'd0, e.whilo, e.whilo});
          chk("wd_be", 64'(wd_b), 64'(e.wd_b));
          chk("wd_le", 64'(wd_l), 64'(e.wd_l));
          chk("hi", {hi_b, hi_l}, {e.hi, e.hi});
          chk("lo", {lo_b, lo_l}, {e.lo, e.lo});
          chk("err", {62'd0, err_b, err_l}, {62'd0, e.err, e.err});
        end
      end else begin
        chk("idle_enables", {60'd0, wreg_b, whilo_b, wreg_l, whilo_l}, 64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge on which the commit is visible.
  task automatic issue(input bit ld, input logic [4:0] a, input bit wr, input bit wh,
                       input logic [DW-1:0] dr, input logic [2*DW-1:0] hl, input logic [1:0] sz,
                       input bit u, input logic [1:0] of, input logic [DW-1:0] data, input int d);
    exp_t x;
    int n;
    int unsigned acc;
    bit t;
    mem_valid = 1'b1; mreg = ld; wa = a; wreg = wr; whilo = wh; dreg = dr; dhilo = hl;
    size = sz; uns = u; off = of;
    dm_valid = 1'($urandom_range(0, 1));
    dm = $urandom;
    n = 0;
    while (!(rdy_b && rdy_l)) begin
      if (n == 50) begin
        checks++; errors++;
        $display("FAIL ready_wait: got mem_ready low for 50 cycles expected high");
        mem_valid = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    x.wa = a;
`ifdef WB_HILO_COMMIT_EN
    x.whilo = wh; x.hi = hl[2*DW-1:DW]; x.lo = hl[DW-1:0];
`else
    x.whilo = 1'b0; x.hi = '0; x.lo = '0;
`endif
    if (!ld) begin
      x.cyc = acc; x.wreg = wr; x.wd_b = dr; x.wd_l = dr;
    end else begin
      t = (d > TO + 1);
      x.cyc  = acc + (t ? TO + 1 : d);
      x.wreg = t ? 1'b0 : wr;
      x.wd_b = t ? '0 : model_load(data, int'(sz), u, int'(of), 1'b1);
      x.wd_l = t ? '0 : model_load(data, int'(sz), u, int'(of), 1'b0);
      if (t) model_err = 1'b1;
    end
    x.err = model_err;
    q.push_back(x);
    @(negedge clk);
    mem_valid = 1'b0;
    dm_valid = 1'b0;
    if (ld) begin
      for (int i = 1; i <= TO + 1; i++) begin
        dm_valid = (i == d);
        dm = (i == d) ? data : $urandom;
        @(negedge clk);
        if (i == d) break;
      end
      dm_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready", {62'd0, rdy_b, rdy_l}, 64'd0);
    chk("reset_ctrl", {54'd0, v_b, wreg_b, whilo_b, err_b, v_l, wreg_l, whilo_l, err_l, 2'd0}, 64'd0);
    chk("reset_data", {wd_b | hi_b | lo_b, wd_l | hi_l | lo_l}, 64'd0);
    chk("reset_wa", {54'd0, wa_b, wa_l}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1, 5'd3, 1, 0, '0, '0, 2'd0, 0, 2'd1, 32'h1180_3344, 3);
    issue(1, 5'd4, 1, 0, '0, '0, 2'd1, 1, 2'd2, 32'h1122_A1B2, 1);
    issue(1, 5'd5, 1, 0, '0, '0, 2'd1, 1, 2'd0, 32'h1122_A1B2, 2);
    issue(1, 5'd6, 1, 0, '0, '0, 2'd3, 0, 2'd1, 32'h8765_4321, 16);
    issue(0, 5'd7, 1, 1, 32'hDEAD_BEEF, 64'h1234_5678_9ABC_DEF0, 2'd0, 0, 2'd0, '0, 0);
    issue(1, 5'd8, 1, 0, '0, '0, 2'd2, 0, 2'd0, '0, 99);

    for (int i = 1; i <= 3; i++) begin
      chk("b2b_ready", {62'd0, rdy_b, rdy_l}, 64'd3);
      issue(0, 5'(i), 1, 0, DW'(i), '0, 2'd0, 0, 2'd0, '0, 0);
    end
    repeat (2) @(negedge clk);

    // Reset while a load is pending; late load data must not commit.
    mem_valid = 1'b1; mreg = 1'b1; wa = 5'd9; wreg = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_wait_ready", {62'd0, rdy_b, rdy_l}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_err = 1'b0;
    dm_valid = 1'b1; dm = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    dm_valid = 1'b0;
    chk("rst_wait_ctrl", {54'd0, v_b, wreg_b, whilo_b, err_b, v_l, wreg_l, whilo_l, err_l, 2'd0}, 64'd0);
    chk("rst_wait_data", {wd_b | hi_b | lo_b, wd_l | hi_l | lo_l}, 64'd0);
    chk("rst_wait_wa", {54'd0, wa_b, wa_l}, 64'd0);

    for (int k = 0; k < 300; k++) begin
      issue(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom), 1'($urandom), $urandom,
            {$urandom, $urandom}, 2'($urandom), 1'($urandom), 2'($urandom), $urandom,
            int'($urandom_range(1, 20)));
      repeat ($urandom_range(0, 2)) begin
        dm_valid = 1'($urandom);
        dm = $urandom;
        @(negedge clk);
      end
      dm_valid = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
